// File: rtl/ifu_axil_fetch.sv
// Instruction-fetch bridge: one outstanding AXI-lite read per PC request, misaligned PCs answered locally.
// Optional watchdog on the memory side enabled by defining IFU_TIMEOUT_EN.
module ifu_axil_fetch #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [31:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD
    } state_t;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic [ADDR_W-1:0] r_maddr;
    logic [31:0]       r_cnt;
    logic              w_aligned;
    logic              w_timeout;

    assign w_aligned = (araddr[1:0] == 2'b00);

`ifdef IFU_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC) : 8;

    logic [TW-1:0] r_wdog;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (r_state == S_IDLE && w_next == S_ADDR) begin
            r_wdog <= '0;
        end else if (r_state == S_ADDR || r_state == S_DATA) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_ADDR || r_state == S_DATA) &&
                       (r_wdog == TW'(TIMEOUT_CYC - 1));
`else
    // No watchdog in this build; the parameter stays for interface compatibility.
    assign w_timeout = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // In ADDR the watchdog wins over a coincident m_arready; in DATA returned data wins.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (arvalid) begin
                    w_next = w_aligned ? S_ADDR : S_HOLD;
                end
            end
            S_ADDR: begin
                if (w_timeout) begin
                    w_next = S_HOLD;
                end else if (m_arready) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (m_rvalid || w_timeout) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (rready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= '0;
            r_maddr <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arvalid) begin
                        if (w_aligned) begin
                            r_maddr <= araddr;
                        end else begin
                            r_rdata <= '0;
                            r_rresp <= RESP_SLVERR;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_timeout) begin
                        r_rdata <= '0;
                        r_rresp <= RESP_SLVERR;
                    end
                end
                S_DATA: begin
                    if (m_rvalid) begin
                        r_rdata <= m_rdata;
                        r_rresp <= m_rresp;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_rresp <= RESP_SLVERR;
                    end
                end
                S_HOLD: begin
                    if (rready) begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign arready   = (r_state == S_IDLE);
    assign m_arvalid = (r_state == S_ADDR);
    assign m_rready  = (r_state == S_DATA);
    assign rvalid    = (r_state == S_HOLD);
    assign rdata     = r_rdata;
    assign rresp     = r_rresp;
    assign m_araddr  = r_maddr;
    assign fetch_cnt = r_cnt;

endmodule

// File: tb/tb_ifu_axil_fetch.sv
// Bench for ifu_axil_fetch: delay-configurable instruction memory plus a transaction-level expectation model.
module tb_ifu_axil_fetch;

`ifdef IFU_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    ifu_axil_fetch #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYC(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory: address accepted after mem_ar_delay wait cycles, data after mem_r_delay more.
    int          mem_ar_delay = 0;
    int          mem_r_delay  = 0;
    bit          mem_never    = 1'b0;
    logic [1:0]  mem_resp     = 2'b00;
    logic [31:0] mem_words [16];
    int          ar_wait;
    int          r_wait;
    bit          pend;
    logic [31:0] pend_addr;

    assign m_arready = m_arvalid && !mem_never && (ar_wait >= mem_ar_delay);
    assign m_rvalid  = pend && (r_wait >= mem_r_delay);
    assign m_rdata   = pend ? mem_words[pend_addr[5:2]] : 32'h0;
    assign m_rresp   = mem_resp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_wait   <= 0;
            r_wait    <= 0;
            pend      <= 1'b0;
            pend_addr <= '0;
        end else begin
            if (m_arvalid && m_arready) begin
                ar_wait   <= 0;
                pend      <= 1'b1;
                pend_addr <= m_araddr;
                r_wait    <= 0;
            end else if (m_arvalid) begin
                ar_wait <= ar_wait + 1;
            end
            if (pend) begin
                if (m_rvalid && m_rready) pend <= 1'b0;
                else r_wait <= r_wait + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "global timeout");
    end

    // Drives one fetch starting at a negedge and returns what was observed; callers judge it.
    task automatic run_fetch(input logic [31:0] a, input int hold,
                             output int lat, output logic [31:0] d, output logic [1:0] r,
                             output bit saw_mar, output bit addr_bad, output bit hold_bad,
                             output bit ready_start, output bit ready_after);
        ready_start = arready;
        araddr  = a;
        arvalid = 1'b1;
        rready  = 1'b0;
        @(negedge clk);
        arvalid  = 1'b0;
        lat      = 1;
        saw_mar  = 1'b0;
        addr_bad = 1'b0;
        while (!rvalid && lat < 400) begin
            if (m_arvalid) begin
                saw_mar = 1'b1;
                if (m_araddr !== a) addr_bad = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
        d = rdata;
        r = rresp;
        hold_bad = 1'b0;
        araddr  = ~a;
        arvalid = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!rvalid || rdata !== d || rresp !== r || arready || m_arvalid || m_rready)
                hold_bad = 1'b1;
        end
        rready = 1'b1;
        @(negedge clk);
        rready  = 1'b0;
        arvalid = 1'b0;
        ready_after = arready && !rvalid;
        if (lat < 400) exp_cnt++;
    endtask

    task automatic test_reset();
        for (int unsigned i = 0; i < 16; i++) mem_words[i] = $urandom;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready: got %b want 1", arready); end
        checks++; if ({rvalid, m_arvalid, m_rready} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b want 000", {rvalid, m_arvalid, m_rready}); end
        checks++; if (rdata !== 32'h0 || rresp !== 2'b00) begin errors++; $display("FAIL reset_rdata: got %h/%b want 0/00", rdata, rresp); end
        checks++; if (m_araddr !== 32'h0 || fetch_cnt !== 32'h0) begin errors++; $display("FAIL reset_regs: got %h/%h want 0/0", m_araddr, fetch_cnt); end
        exp_cnt = 0;
    endtask

    task automatic test_aligned();
        int lat; logic [31:0] d; logic [1:0] r; bit sm, ab, hb, rs, ra;
        mem_words[0] = 32'h0010_0093;
        mem_ar_delay = 0; mem_r_delay = 0; mem_resp = 2'b00;
        run_fetch(32'h8000_0000, 0, lat, d, r, sm, ab, hb, rs, ra);
        checks++; if (rs !== 1'b1) begin errors++; $display("FAIL aligned_arready: got %b want 1", rs); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL aligned_latency: got %0d want 3", lat); end
        checks++; if (d !== 32'h0010_0093 || r !== 2'b00) begin errors++; $display("FAIL aligned_data: got %h/%b want 00100093/00", d, r); end
        checks++; if (!sm || ab) begin errors++; $display("FAIL aligned_maddr: saw=%b bad=%b want 1/0", sm, ab); end
        checks++; if (fetch_cnt !== 32'd1) begin errors++; $display("FAIL aligned_cnt: got %0d want 1", fetch_cnt); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL aligned_ready_after: got %b want 1", ra); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] d; logic [1:0] r; bit sm, ab, hb, rs, ra;
        logic [31:0] addrs [3] = '{32'h8000_0002, 32'h8000_0101, 32'h0000_0047};
        for (int unsigned i = 0; i < 3; i++) begin
            run_fetch(addrs[i], 0, lat, d, r, sm, ab, hb, rs, ra);
            checks++; if (lat !== 1) begin errors++; $display("FAIL misaligned_latency[%0d]: got %0d want 1", i, lat); end
            checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL misaligned_resp[%0d]: got %h/%b want 0/10", i, d, r); end
            checks++; if (sm !== 1'b0) begin errors++; $display("FAIL misaligned_no_mem[%0d]: m_arvalid seen=%b want 0", i, sm); end
            checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL misaligned_cnt[%0d]: got %0d want %0d", i, fetch_cnt, exp_cnt); end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] d; logic [1:0] r; bit sm, ab, hb, rs, ra;
        mem_ar_delay = 0; mem_r_delay = 1; mem_resp = 2'b00;
        run_fetch(32'h0000_0024, 10, lat, d, r, sm, ab, hb, rs, ra);
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", lat); end
        checks++; if (d !== mem_words[9] || r !== 2'b00) begin errors++; $display("FAIL bp_data: got %h/%b want %h/00", d, r, mem_words[9]); end
        checks++; if (hb !== 1'b0) begin errors++; $display("FAIL bp_hold_stable: got %b want 0", hb); end
        checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL bp_cnt: got %0d want %0d", fetch_cnt, exp_cnt); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", ra); end
    endtask

    task automatic test_slow_mem();
        int lat; logic [31:0] d; logic [1:0] r; bit sm, ab, hb, rs, ra;
        mem_ar_delay = 4; mem_r_delay = 0; mem_resp = 2'b10;
        run_fetch(32'h1234_5678, 0, lat, d, r, sm, ab, hb, rs, ra);
        checks++; if (lat !== 7) begin errors++; $display("FAIL slow_latency: got %0d want 7", lat); end
        checks++; if (ab !== 1'b0 || sm !== 1'b1) begin errors++; $display("FAIL slow_maddr_stable: bad=%b saw=%b want 0/1", ab, sm); end
        checks++; if (d !== mem_words[14] || r !== 2'b10) begin errors++; $display("FAIL slow_resp: got %h/%b want %h/10", d, r, mem_words[14]); end
        checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL slow_cnt: got %0d want %0d", fetch_cnt, exp_cnt); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] d; logic [1:0] r; bit sm, ab, hb, rs, ra;
        logic [31:0] a; logic [31:0] exp_d; logic [1:0] exp_r; int exp_lat; int hold;
        for (int unsigned i = 0; i < 24; i++) begin
            mem_words[$urandom_range(15, 0)] = $urandom;
            a = $urandom;
            if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
            mem_ar_delay = $urandom_range(3, 0);
            mem_r_delay  = $urandom_range(3, 0);
            mem_resp     = 2'($urandom_range(3, 0));
            hold         = $urandom_range(3, 0);
            if (a[1:0] != 2'b00) begin
                exp_d = 32'h0; exp_r = 2'b10; exp_lat = 1;
            end else begin
                exp_d = mem_words[a[5:2]]; exp_r = mem_resp; exp_lat = 3 + mem_ar_delay + mem_r_delay;
            end
            run_fetch(a, hold, lat, d, r, sm, ab, hb, rs, ra);
            checks++; if (rs !== 1'b1 || lat !== exp_lat) begin errors++; $display("FAIL rnd_latency[%0d]: ready=%b got %0d want %0d", i, rs, lat, exp_lat); end
            checks++; if (d !== exp_d || r !== exp_r) begin errors++; $display("FAIL rnd_data[%0d]: got %h/%b want %h/%b", i, d, r, exp_d, exp_r); end
            checks++; if (ab || hb || sm !== (a[1:0] == 2'b00)) begin errors++; $display("FAIL rnd_protocol[%0d]: addr_bad=%b hold_bad=%b saw=%b", i, ab, hb, sm); end
            checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, fetch_cnt, exp_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mem_ar_delay = 0; mem_r_delay = 50; mem_resp = 2'b00;
        araddr = 32'h0000_0010; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!m_rready && n < 20) begin @(negedge clk); n++; end
        checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL rstmid_reach_data: got %b want 1", m_rready); end
        checks++; if (fetch_cnt === 32'h0) begin errors++; $display("FAIL rstmid_precount: got %0d want nonzero", fetch_cnt); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({arready, rvalid, m_arvalid, m_rready} !== 4'b1000) begin errors++; $display("FAIL rstmid_state: got %b want 1000", {arready, rvalid, m_arvalid, m_rready}); end
        checks++; if (fetch_cnt !== 32'h0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", fetch_cnt); end
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_no_response();
        mem_never = 1'b1;
        mem_ar_delay = 0; mem_r_delay = 0; mem_resp = 2'b00;
`ifdef IFU_TIMEOUT_EN
        begin
            int lat; logic [31:0] d; logic [1:0] r; bit sm, ab, hb, rs, ra;
            run_fetch(32'h8000_0010, 0, lat, d, r, sm, ab, hb, rs, ra);
            checks++; if (lat !== TB_TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", lat, TB_TIMEOUT + 1); end
            checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++; $display("FAIL timeout_resp: got %h/%b want 0/10", d, r); end
            checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL timeout_cnt: got %0d want %0d", fetch_cnt, exp_cnt); end
        end
`else
        begin
            bit seen;
            araddr = 32'h8000_0010; arvalid = 1'b1;
            @(negedge clk);
            arvalid = 1'b0;
            seen = 1'b0;
            repeat (300) begin
                if (rvalid) seen = 1'b1;
                @(negedge clk);
            end
            checks++; if (seen !== 1'b0) begin errors++; $display("FAIL noresp_rvalid: got %b want 0", seen); end
            checks++; if (m_arvalid !== 1'b1) begin errors++; $display("FAIL noresp_waiting: got %b want 1", m_arvalid); end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            exp_cnt = 0;
            @(negedge clk);
        end
`endif
        mem_never = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_misaligned();
        test_backpressure();
        test_slow_mem();
        test_random();
        test_reset_mid();
        test_no_response();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
